// File: rtl/io_input_conditioner.sv
// -----------------------------------------------------------------------------
// io_input_conditioner
//
// Conditions raw board inputs for the LSU input buffer.
//   * 32 switches: plain 2-flop synchronizer, no debounce.
//   * 4 buttons:   optional inversion (so pressed reads as 1), 2-flop
//                  synchronizer, per-button debounce counter, rising-edge
//                  (press) detection, sticky press-event bits and a single
//                  one-cycle acknowledge strobe for any accepted press.
//
// Parameters
//   DB_CYCLES      consecutive mismatching synchronized samples needed to
//                  accept a new button level (legal: 2 .. 2**DB_CNT_W - 1)
//   DB_CNT_W       width of each debounce counter
//   BTN_ACTIVE_LOW 1: raw buttons are inverted before synchronization
//
// Ports
//   i_clk         clock, all state updates on the rising edge
//   i_rst_n       asynchronous active-low reset
//   i_io_sw_raw   [31:0] raw switch pins (asynchronous)
//   i_io_btn_raw  [3:0]  raw button pins (asynchronous)
//   i_evt_clr     clears all sticky press events (a same-edge press wins)
//   o_io_sw       [31:0] synchronized switch levels
//   o_io_btn      [3:0]  debounced button levels, 1 = pressed
//   o_btn_evt     [3:0]  sticky press-event bits
//   o_ack         one-cycle pulse on any accepted press
// -----------------------------------------------------------------------------
module io_input_conditioner #(
  parameter int DB_CYCLES      = 50000,
  parameter int DB_CNT_W       = 16,
  parameter bit BTN_ACTIVE_LOW = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_io_sw_raw,
  input  logic [3:0]  i_io_btn_raw,
  input  logic        i_evt_clr,
  output logic [31:0] o_io_sw,
  output logic [3:0]  o_io_btn,
  output logic [3:0]  o_btn_evt,
  output logic        o_ack
);

  localparam int NUM_BTN = 4;

  // Terminal count: the counter never goes past this value, so it cannot wrap.
  localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DB_CYCLES - 1);
  localparam logic [DB_CNT_W-1:0] CNT_ONE = DB_CNT_W'(1);

  // Synchronizers
  logic [31:0] sw_ff1, sw_ff2;
  logic [3:0]  btn_in;            // polarity-corrected raw buttons
  logic [3:0]  btn_ff1, btn_ff2;  // btn_ff2 is the synchronized level 's'

  // Debouncer state and next-state
  logic [3:0]          stable, stable_nxt;
  logic [DB_CNT_W-1:0] cnt     [NUM_BTN];
  logic [DB_CNT_W-1:0] cnt_nxt [NUM_BTN];
  logic [3:0]          press;     // stable rises on this edge

  // Sticky events and strobe
  logic [3:0] btn_evt;
  logic       ack;

  assign btn_in = BTN_ACTIVE_LOW ? ~i_io_btn_raw : i_io_btn_raw;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizers for switches and buttons.
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the two stages into one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sw_ff1  <= '0;
      sw_ff2  <= '0;
      btn_ff1 <= '0;
      btn_ff2 <= '0;
    end else begin
      sw_ff1  <= i_io_sw_raw;
      sw_ff2  <= sw_ff1;
      btn_ff1 <= btn_in;
      btn_ff2 <= btn_ff1;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce next-state. Any sample matching the accepted level restarts the
  // count; DB_CYCLES consecutive mismatches accept the new level.
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    stable_nxt = stable;
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt_nxt[i] = '0;
      if (btn_ff2[i] == stable[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt[i] == DB_LAST) begin
        stable_nxt[i] = btn_ff2[i];
        cnt_nxt[i]    = '0;
      end else begin
        cnt_nxt[i] = cnt[i] + CNT_ONE;
      end
    end
    press = stable_nxt & ~stable;
  end

  // ---------------------------------------------------------------------------
  // Debounce state, sticky events and the registered acknowledge strobe.
  // ---------------------------------------------------------------------------
  // NOTE: the counter array is only four entries of control state, so it is
  // reset explicitly; a reset mid-debounce must discard any partial count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stable  <= '0;
      btn_evt <= '0;
      ack     <= 1'b0;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      stable <= stable_nxt;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
      // Set has priority over clear so a press coinciding with a clear is kept.
      btn_evt <= (btn_evt & ~{NUM_BTN{i_evt_clr}}) | press;
      // Several simultaneous presses still give a single pulse.
      ack     <= |press;
    end
  end

  assign o_io_sw   = sw_ff2;
  assign o_io_btn  = stable;
  assign o_btn_evt = btn_evt;
  assign o_ack     = ack;

endmodule

// File: tb/tb_io_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_io_input_conditioner
//
// Self-checking bench for io_input_conditioner with DB_CYCLES=4 and
// active-low buttons. A reference model derives the outputs from the input
// history: a button's accepted level flips when the last DB_CYCLES
// synchronized samples all disagree with it; switches appear two samples late.
// A compare process checks every cycle; directed scenarios add literal checks.
// -----------------------------------------------------------------------------
module tb_io_input_conditioner;

  localparam int DB = 4;
  localparam int HIST = 8;

  logic        clk;
  logic        rst_n;
  logic [31:0] sw_raw;
  logic [3:0]  btn_raw;
  logic        evt_clr;
  logic [31:0] io_sw;
  logic [3:0]  io_btn;
  logic [3:0]  btn_evt;
  logic        ack;

  int vectors;
  int miscompares;
  int ack_cnt;

  io_input_conditioner #(
    .DB_CYCLES      (DB),
    .DB_CNT_W       (16),
    .BTN_ACTIVE_LOW (1'b1)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_io_sw_raw  (sw_raw),
    .i_io_btn_raw (btn_raw),
    .i_evt_clr    (evt_clr),
    .o_io_sw      (io_sw),
    .o_io_btn     (io_btn),
    .o_btn_evt    (btn_evt),
    .o_ack        (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. m_hist[0] is the most recent pressed-level sample
  // (pins inverted), m_hist[j] the one j edges earlier. Before an edge,
  // the synchronized sample the debouncer sees is m_hist[1].
  // ---------------------------------------------------------------------------
  logic [HIST-1:0][3:0] m_hist;
  logic [31:0]          m_sw0, m_sw1;
  logic [3:0]           m_stable, m_evt, m_next, m_press;
  logic                 m_ack;

  function automatic logic [3:0] next_level(input logic [3:0] st,
                                            input logic [HIST-1:0][3:0] h);
    logic [3:0] r;
    r = st;
    for (int i = 0; i < 4; i++) begin
      bit all_differ;
      all_differ = 1'b1;
      for (int j = 1; j <= DB; j++) begin
        if (h[j][i] == st[i]) all_differ = 1'b0;
      end
      if (all_differ) r[i] = ~st[i];
    end
    return r;
  endfunction

  assign m_next  = next_level(m_stable, m_hist);
  assign m_press = m_next & ~m_stable;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hist   <= '0;
      m_sw0    <= '0;
      m_sw1    <= '0;
      m_stable <= '0;
      m_evt    <= '0;
      m_ack    <= 1'b0;
    end else begin
      m_hist   <= {m_hist[HIST-2:0], ~btn_raw};
      m_sw0    <= sw_raw;
      m_sw1    <= m_sw0;
      m_stable <= m_next;
      m_evt    <= (m_evt & ~{4{evt_clr}}) | m_press;
      m_ack    <= |m_press;
    end
  end

  always @(posedge clk) begin
    if (ack === 1'b1) ack_cnt <= ack_cnt + 1;
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("sw",  io_sw,          m_sw1);
    check("btn", 32'(io_btn),    32'(m_stable));
    check("evt", 32'(btn_evt),   32'(m_evt));
    check("ack", 32'(ack),       32'(m_ack));
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int base;
    int hold [4];
    logic [3:0] lvl;

    vectors     = 0;
    miscompares = 0;
    ack_cnt     = 0;
    rst_n       = 1'b1;
    sw_raw      = 32'h1234_5678;
    btn_raw     = 4'b0000;
    evt_clr     = 1'b0;

    // Reset: asserted asynchronously mid-cycle, all buttons pressed at pins.
    #2 rst_n = 1'b0;
    #1;
    check("rst_sw",  io_sw,       32'h0);
    check("rst_btn", 32'(io_btn), 32'h0);
    check("rst_evt", 32'(btn_evt), 32'h0);
    check("rst_ack", 32'(ack),    32'h0);
    cycles(10);
    check("rst_hold_btn", 32'(io_btn), 32'h0);
    rst_n = 1'b1;
    cycles(2);
    check("post_rst_btn", 32'(io_btn), 32'h0);
    // Pins change back before the debounce window fills: no level accepted.
    btn_raw = 4'b1111;
    cycles(10);
    check("post_rst_btn_idle", 32'(io_btn), 32'h0);
    check("post_rst_ack_none", 32'(ack_cnt), 32'h0);

    // Clean press on btn0.
    base = ack_cnt;
    btn_raw = 4'b1110;
    cycles(5);
    check("press_btn_early", 32'(io_btn), 32'h0);
    check("press_ack_early", 32'(ack),    32'h0);
    cycles(1);
    check("press_btn",  32'(io_btn),  32'h1);
    check("press_evt",  32'(btn_evt), 32'h1);
    check("press_ack",  32'(ack),     32'h1);
    cycles(1);
    check("press_ack_fall", 32'(ack), 32'h0);
    cycles(10);
    check("press_hold_one_ack", 32'(ack_cnt - base), 32'h1);

    // Release btn0, clear events.
    btn_raw = 4'b1111;
    cycles(8);
    evt_clr = 1'b1;
    cycles(1);
    evt_clr = 1'b0;
    check("clr_evt", 32'(btn_evt), 32'h0);

    // Glitch rejection: 3-sample pulse on btn1.
    base = ack_cnt;
    btn_raw = 4'b1101;
    cycles(3);
    btn_raw = 4'b1111;
    cycles(10);
    check("glitch_btn", 32'(io_btn),  32'h0);
    check("glitch_evt", 32'(btn_evt), 32'h0);
    check("glitch_ack", 32'(ack_cnt - base), 32'h0);
    // 4-sample pulse is accepted.
    btn_raw = 4'b1101;
    cycles(4);
    btn_raw = 4'b1111;
    cycles(12);
    check("pulse4_evt", 32'(btn_evt), 32'h2);
    check("pulse4_ack", 32'(ack_cnt - base), 32'h1);
    check("pulse4_btn_released", 32'(io_btn), 32'h0);

    // Clear/set collision.
    evt_clr = 1'b1;
    cycles(1);
    evt_clr = 1'b0;
    btn_raw = 4'b1110;
    cycles(6);
    check("coll_pre_evt", 32'(btn_evt), 32'h1);
    btn_raw = 4'b1010;
    cycles(5);
    evt_clr = 1'b1;
    cycles(1);
    check("coll_evt", 32'(btn_evt), 32'h4);
    check("coll_btn", 32'(io_btn),  32'h5);
    cycles(1);
    evt_clr = 1'b0;
    check("coll_clear_only", 32'(btn_evt), 32'h0);

    // Simultaneous presses and release.
    btn_raw = 4'b1111;
    cycles(12);
    base = ack_cnt;
    btn_raw = 4'b0110;
    cycles(8);
    check("simul_ack", 32'(ack_cnt - base), 32'h1);
    check("simul_evt", 32'(btn_evt), 32'h9);
    check("simul_btn", 32'(io_btn),  32'h9);
    btn_raw = 4'b1111;
    cycles(8);
    check("release_btn", 32'(io_btn), 32'h0);
    check("release_ack", 32'(ack_cnt - base), 32'h1);

    // Switch latency.
    sw_raw = 32'hA5A5_0F0F;
    cycles(1);
    check("sw_prev", io_sw, 32'h1234_5678);
    cycles(1);
    check("sw_new",  io_sw, 32'hA5A5_0F0F);

    // Randomized phase: per-button hold times of 1..7 samples mix glitches
    // with accepted presses; clears and switch values are random.
    for (int i = 0; i < 4; i++) hold[i] = 0;
    lvl = btn_raw;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (hold[i] == 0) begin
          lvl[i]  = 1'($urandom_range(0, 1));
          hold[i] = $urandom_range(1, 7);
        end else begin
          hold[i]--;
        end
      end
      btn_raw = lvl;
      sw_raw  = $urandom;
      evt_clr = ($urandom_range(0, 7) == 0);
      cycles(1);
    end
    evt_clr = 1'b0;

    // Asynchronous reset from a busy state.
    btn_raw = 4'b0000;
    sw_raw  = 32'hFFFF_FFFF;
    cycles(8);
    check("pre_rst2_btn", 32'(io_btn), 32'hF);
    #2 rst_n = 1'b0;
    #1;
    check("rst2_sw",  io_sw,        32'h0);
    check("rst2_btn", 32'(io_btn),  32'h0);
    check("rst2_evt", 32'(btn_evt), 32'h0);
    check("rst2_ack", 32'(ack),     32'h0);
    cycles(3);
    rst_n = 1'b1;
    cycles(3);
    check("rst2_partial_btn", 32'(io_btn), 32'h0);
    cycles(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
